// File: rtl/csr_pkg.sv
// Shared CSR types, addresses and write-mask helper for csr_file and its counters.
// The optional minstret counter is controlled by CSR_INSTRET_EN (see csr_file).
package csr_pkg;

  localparam int unsigned CSR_XLEN = 64;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MSTATUS  = 12'h300;
  localparam csr_addr_t CSR_MIE      = 12'h304;
  localparam csr_addr_t CSR_MTVEC    = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH = 12'h340;
  localparam csr_addr_t CSR_MEPC     = 12'h341;
  localparam csr_addr_t CSR_MCAUSE   = 12'h342;
  localparam csr_addr_t CSR_MIP      = 12'h344;
  localparam csr_addr_t CSR_SATP     = 12'h180;
  localparam csr_addr_t CSR_MCYCLE   = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET = 12'hB02;

  localparam logic [CSR_XLEN-1:0] MSTATUS_MASK = 64'h0000_0000_0000_1888;

  typedef struct packed {
    logic [50:0] rsvd_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_mid;
    logic        mpie;
    logic [2:0]  rsvd_lo2;
    logic        mie;
    logic [2:0]  rsvd_lo;
  } mstatus_t;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_M = 2'b11
  } priv_e;

  // Writable bits per address; unimplemented or read-only-zero CSRs get an all-zero mask.
  function automatic logic [CSR_XLEN-1:0] csr_wmask(input csr_addr_t addr,
                                                    input logic instret_en);
    logic [CSR_XLEN-1:0] mask;
    mask = '0;
    case (addr)
      CSR_MSTATUS:  mask = MSTATUS_MASK;
      CSR_MTVEC:    mask = ~64'h3;
      CSR_MEPC:     mask = ~64'h1;
      CSR_MIE, CSR_MSCRATCH, CSR_MCAUSE, CSR_SATP, CSR_MCYCLE: mask = '1;
      CSR_MINSTRET: mask = instret_en ? '1 : '0;
      default:      mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with synchronous reset and a load that overrides the increment.
module csr_counter #(
  parameter int unsigned Width = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_data,
  output logic [Width-1:0] o_value
);

  logic [Width-1:0] r_value;
  logic [Width-1:0] w_next;

  always_comb begin
    w_next = r_value + Width'(i_inc);
    if (i_load) w_next = i_load_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_value <= '0;
    else         r_value <= w_next;
  end

  assign o_value = r_value;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: storage, combinational reads with write bypass, trap entry and mret.
// Define CSR_INSTRET_EN to implement minstret (0xB02); otherwise it reads 0.
module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra,
  output logic [XLEN-1:0]   rd,
  input  logic              csrwrite,
  input  logic [ADDR_W-1:0] csr_dst,
  input  logic [XLEN-1:0]   csrdata,
  input  logic              retire,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic              mret_valid,
  output logic [XLEN-1:0]   mtvec_o,
  output logic [XLEN-1:0]   mepc_o,
  output logic [XLEN-1:0]   satp_o,
  output logic [1:0]        mode_o
);

`ifdef CSR_INSTRET_EN
  localparam logic InstretEn = 1'b1;
`else
  localparam logic InstretEn = 1'b0;
`endif

  mstatus_t        r_mstatus;
  logic [XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_satp;
  logic [1:0]      r_mode;
  logic [XLEN-1:0] w_mcycle, w_minstret, w_wdata;
  logic            w_mret, w_wr;

  // Lower-priority events are dropped whole when a higher one commits.
  assign w_mret  = mret_valid & ~trap_valid;
  assign w_wr    = csrwrite & ~trap_valid & ~mret_valid;
  assign w_wdata = csrdata & csr_wmask(csr_dst, InstretEn);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mstatus  <= '0;
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_satp     <= '0;
      r_mode     <= PRIV_M;
    end else if (trap_valid) begin
      r_mepc         <= trap_pc & ~64'h1;
      r_mcause       <= trap_cause;
      r_mstatus.mpie <= r_mstatus.mie;
      r_mstatus.mie  <= 1'b0;
      r_mstatus.mpp  <= r_mode;
      r_mode         <= PRIV_M;
    end else if (w_mret) begin
      r_mode         <= r_mstatus.mpp;
      r_mstatus.mie  <= r_mstatus.mpie;
      r_mstatus.mpie <= 1'b1;
      r_mstatus.mpp  <= PRIV_U;
    end else if (w_wr) begin
      case (csr_dst)
        CSR_MSTATUS:  r_mstatus  <= mstatus_t'(w_wdata);
        CSR_MIE:      r_mie      <= w_wdata;
        CSR_MTVEC:    r_mtvec    <= w_wdata;
        CSR_MSCRATCH: r_mscratch <= w_wdata;
        CSR_MEPC:     r_mepc     <= w_wdata;
        CSR_MCAUSE:   r_mcause   <= w_wdata;
        CSR_SATP:     r_satp     <= w_wdata;
        default:      ;
      endcase
    end
  end

  csr_counter #(.Width(XLEN)) u_mcycle (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_inc       (1'b1),
    .i_load      (w_wr && (csr_dst == CSR_MCYCLE)),
    .i_load_data (w_wdata),
    .o_value     (w_mcycle)
  );

`ifdef CSR_INSTRET_EN
  csr_counter #(.Width(XLEN)) u_minstret (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_inc       (retire),
    .i_load      (w_wr && (csr_dst == CSR_MINSTRET)),
    .i_load_data (w_wdata),
    .o_value     (w_minstret)
  );
`else
  logic w_unused_retire;
  assign w_unused_retire = retire;
  assign w_minstret      = '0;
`endif

  always_comb begin
    rd = '0;
    case (ra)
      CSR_MSTATUS:  rd = r_mstatus;
      CSR_MIE:      rd = r_mie;
      CSR_MTVEC:    rd = r_mtvec;
      CSR_MSCRATCH: rd = r_mscratch;
      CSR_MEPC:     rd = r_mepc;
      CSR_MCAUSE:   rd = r_mcause;
      CSR_SATP:     rd = r_satp;
      CSR_MCYCLE:   rd = w_mcycle;
      CSR_MINSTRET: rd = w_minstret;
      default:      rd = '0;
    endcase
    if (csrwrite && (csr_dst == ra)) rd = csrdata & csr_wmask(ra, InstretEn);
  end

  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;
  assign satp_o  = r_satp;
  assign mode_o  = r_mode;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; exercises minstret when CSR_INSTRET_EN is defined.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] ra, csr_dst;
  logic [63:0] rd, csrdata, trap_pc, trap_cause, mtvec_o, mepc_o, satp_o;
  logic        csrwrite, retire, trap_valid, mret_valid;
  logic [1:0]  mode_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  csr_file u_dut (
    .clk        (clk),
    .reset      (reset),
    .ra         (ra),
    .rd         (rd),
    .csrwrite   (csrwrite),
    .csr_dst    (csr_dst),
    .csrdata    (csrdata),
    .retire     (retire),
    .trap_valid (trap_valid),
    .trap_pc    (trap_pc),
    .trap_cause (trap_cause),
    .mret_valid (mret_valid),
    .mtvec_o    (mtvec_o),
    .mepc_o     (mepc_o),
    .satp_o     (satp_o),
    .mode_o     (mode_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    csrwrite   = 1'b0;
    csr_dst    = '0;
    csrdata    = '0;
    trap_valid = 1'b0;
    trap_pc    = '0;
    trap_cause = '0;
    mret_valid = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    ra = addr;
    #1;
    check_eq(tag, rd, exp);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [63:0] data);
    csrwrite = 1'b1;
    csr_dst  = addr;
    csrdata  = data;
  endtask

  initial begin
    clear_in();
    retire = 1'b0;
    ra     = '0;
    reset  = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    rd_check("rst_mstatus", 12'h300, 64'h0);
    rd_check("rst_mtvec", 12'h305, 64'h0);
    rd_check("rst_mcycle", 12'hB00, 64'h0);
    check_eq("rst_mode", 64'(mode_o), 64'd3);
    check_eq("rst_mtvec_o", mtvec_o, 64'h0);
    check_eq("rst_mepc_o", mepc_o, 64'h0);
    check_eq("rst_satp_o", satp_o, 64'h0);
    repeat (5) step();
    rd_check("mcycle_5", 12'hB00, 64'd5);

    // mstatus mask and same-cycle bypass
    step();
    wr(12'h300, Ones);
    rd_check("mstatus_bypass", 12'h300, 64'h1888);
    step(); clear_in();
    rd_check("mstatus_wr", 12'h300, 64'h1888);

    // mtvec low bits, mepc bit 0, mip and unimplemented addresses
    wr(12'h305, 64'h8000_0103);
    step(); clear_in();
    rd_check("mtvec_wr", 12'h305, 64'h8000_0100);
    check_eq("mtvec_o", mtvec_o, 64'h8000_0100);
    wr(12'h341, 64'h1235);
    step(); clear_in();
    rd_check("mepc_wr", 12'h341, 64'h1234);
    check_eq("mepc_o_wr", mepc_o, 64'h1234);
    wr(12'h344, Ones);
    rd_check("mip_bypass", 12'h344, 64'h0);
    step(); clear_in();
    rd_check("mip_rd", 12'h344, 64'h0);
    wr(12'h123, Ones);
    rd_check("unimpl_bypass", 12'h123, 64'h0);
    step(); clear_in();
    rd_check("unimpl_rd", 12'h123, 64'h0);

    // satp output has no bypass
    wr(12'h180, 64'hABCD_0000_1234);
    #1;
    check_eq("satp_o_old", satp_o, 64'h0);
    step(); clear_in();
    check_eq("satp_o_new", satp_o, 64'hABCD_0000_1234);

    // mcycle load and wrap
    wr(12'hB00, Ones);
    rd_check("mcycle_bypass", 12'hB00, Ones);
    step(); clear_in();
    rd_check("mcycle_load", 12'hB00, Ones);
    step();
    rd_check("mcycle_wrap", 12'hB00, 64'h0);

    // Trap beats a coincident mepc write
    wr(12'h300, 64'h8);
    step(); clear_in();
    trap_valid = 1'b1;
    trap_pc    = 64'h8000_0010;
    trap_cause = 64'd2;
    wr(12'h341, 64'hDEAD_0000);
    step(); clear_in();
    rd_check("trap_mepc", 12'h341, 64'h8000_0010);
    rd_check("trap_mcause", 12'h342, 64'd2);
    rd_check("trap_mstatus", 12'h300, 64'h1880);
    check_eq("trap_mode", 64'(mode_o), 64'd3);
    check_eq("trap_mepc_o", mepc_o, 64'h8000_0010);

    // MPP=0 then mret; coincident mscratch write is dropped
    step();
    wr(12'h300, 64'h80);
    step(); clear_in();
    mret_valid = 1'b1;
    wr(12'h340, 64'h55);
    step(); clear_in();
    check_eq("mret_mode", 64'(mode_o), 64'd0);
    rd_check("mret_mstatus", 12'h300, 64'h88);
    check_eq("mret_mepc_o", mepc_o, 64'h8000_0010);
    rd_check("mret_drop_wr", 12'h340, 64'h0);

    // Trap wins over mret in the same cycle, from U mode
    step();
    trap_valid = 1'b1;
    trap_pc    = 64'h2000;
    trap_cause = 64'd7;
    mret_valid = 1'b1;
    step(); clear_in();
    check_eq("tm_mode", 64'(mode_o), 64'd3);
    rd_check("tm_mstatus", 12'h300, 64'h80);
    rd_check("tm_mcause", 12'h342, 64'd7);
    rd_check("tm_mepc", 12'h341, 64'h2000);

    // minstret
    step();
`ifdef CSR_INSTRET_EN
    retire = 1'b1;
    repeat (10) step();
    retire = 1'b0;
    rd_check("minstret_10", 12'hB02, 64'd10);
    retire = 1'b1;
    wr(12'hB02, 64'h7);
    step(); clear_in();
    retire = 1'b0;
    rd_check("minstret_wr", 12'hB02, 64'h7);
`else
    retire = 1'b1;
    repeat (3) step();
    wr(12'hB02, 64'h7);
    step(); clear_in();
    retire = 1'b0;
    rd_check("minstret_absent", 12'hB02, 64'h0);
`endif

    // Reset overrides events in the same cycle
    wr(12'h340, 64'h55);
    step(); clear_in();
    rd_check("mscratch_wr", 12'h340, 64'h55);
    reset      = 1'b1;
    trap_valid = 1'b1;
    trap_pc    = 64'h4000;
    wr(12'h340, 64'h9);
    step(); clear_in();
    reset = 1'b0;
    rd_check("rst2_mcycle", 12'hB00, 64'h0);
    rd_check("rst2_mscratch", 12'h340, 64'h0);
    rd_check("rst2_mstatus", 12'h300, 64'h0);
    check_eq("rst2_mode", 64'(mode_o), 64'd3);
    check_eq("rst2_mepc_o", mepc_o, 64'h0);
    check_eq("rst2_satp_o", satp_o, 64'h0);
    check_eq("rst2_mtvec_o", mtvec_o, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
